// File: rtl/mac_pkg.sv
// mac_pkg: shared MAC datapath widths and sequencer state encoding
package mac_pkg;
  localparam int MAC_LANES = 16;
  localparam int MAC_LANE_W = 8;
  localparam int MAC_ACC_W = 2 * MAC_LANE_W + $clog2(MAC_LANES);
  function automatic int acc_w(input int ci_w);
    return MAC_ACC_W + ci_w;
  endfunction
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} seq_state_t;
endpackage

// File: rtl/mac_seq_fifo.sv
// res_fifo2: two-entry ready/valid result FIFO
module res_fifo2 #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] r_mem [2];
  logic         r_wp, r_rp;
  logic [1:0]   r_cnt;
  logic         w_wr, w_rd;
  assign w_wr  = push && !full;
  assign w_rd  = pop && !empty;
  assign full  = r_cnt == 2'd2;
  assign empty = r_cnt == 2'd0;
  assign dout  = r_mem[r_rp];
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_wr) r_mem[r_wp] <= din;
      r_wp  <= r_wp ^ w_wr;
      r_rp  <= r_rp ^ w_rd;
      r_cnt <= r_cnt + 2'(w_wr) - 2'(w_rd);
    end
endmodule

// File: rtl/mac_seq.sv
// mac_seq: walks co/pos/ci over a tile, issues buffer reads and accumulates MAC partial sums
module mac_seq
  import mac_pkg::*;
#(
  parameter int CI_W    = 8,
  parameter int POS_W   = 8,
  parameter int CO_W    = 8,
  parameter int ADDR_W  = 16,
  parameter int BUF_LAT = 1,
  parameter int ACC_W   = acc_w(CI_W)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CI_W-1:0]      cfg_ci_m1,
  input  logic [POS_W-1:0]     cfg_pos_m1,
  input  logic [CO_W-1:0]      cfg_co_m1,
  output logic                 busy,
  output logic                 done,
  output logic                 fbuf_rd_en,
  output logic [ADDR_W-1:0]    fbuf_addr,
  output logic                 wbuf_rd_en,
  output logic [ADDR_W-1:0]    wbuf_addr,
  output logic                 mac_vld_i,
  input  logic [MAC_ACC_W-1:0] mac_acc,
  input  logic                 mac_vld,
  output logic                 out_vld,
  output logic [ACC_W-1:0]     out_data,
  input  logic                 out_rdy
);
  seq_state_t         r_state, w_next;
  logic [CI_W-1:0]    r_ci_m1, r_ci, r_ret_cnt;
  logic [POS_W-1:0]   r_pos_m1, r_pos;
  logic [CO_W-1:0]    r_co_m1, r_co;
  logic [ADDR_W-1:0]  r_fbase, r_wbase, w_step;
  logic [1:0]         r_credit;
  logic [BUF_LAT-1:0] r_vld_sr;
  logic [ACC_W-1:0]   r_acc, w_sum;
  logic w_start, w_issue, w_dec, w_pop, w_last, w_beat, w_push, w_full, w_empty;
  logic w_ci_end, w_pos_end;
  assign w_start   = r_state == IDLE && start;
  assign w_ci_end  = r_ci == r_ci_m1;
  assign w_pos_end = r_pos == r_pos_m1;
  assign w_last    = w_ci_end && w_pos_end && r_co == r_co_m1;
  assign w_step    = ADDR_W'(r_ci_m1) + ADDR_W'(1);
  // a new position needs a free result slot; WAIT always sits at ci==0
  assign w_issue   = (r_state == ISSUE || r_state == WAIT) && (r_ci != '0 || r_credit != 2'd0);
  assign w_dec     = w_issue && r_ci == '0;
  assign w_pop     = out_vld && out_rdy;
  assign w_beat    = mac_vld && r_state != IDLE;
  assign w_sum     = (r_ret_cnt == '0 ? '0 : r_acc) + ACC_W'($signed(mac_acc));
  assign w_push    = w_beat && r_ret_cnt == r_ci_m1 && !w_full;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE  ? (start ? ISSUE : IDLE) :
             r_state == DRAIN ? (done ? IDLE : DRAIN) :
             !w_issue ? WAIT : w_last ? DRAIN : ISSUE;
  always_comb begin
    done       = r_state == DRAIN && r_credit == 2'd1 && w_pop;
    busy       = r_state != IDLE && !done;
    fbuf_rd_en = w_issue;
    wbuf_rd_en = w_issue;
    fbuf_addr  = r_fbase + ADDR_W'(r_ci);
    wbuf_addr  = r_wbase + ADDR_W'(r_ci);
    mac_vld_i  = r_vld_sr[BUF_LAT-1];
    out_vld    = !w_empty;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_ci_m1  <= '0;
      r_pos_m1 <= '0;
      r_co_m1  <= '0;
      r_ci     <= '0;
      r_pos    <= '0;
      r_co     <= '0;
      r_fbase  <= '0;
      r_wbase  <= '0;
      r_credit <= 2'd2;
    end else begin
      if (w_start) begin
        r_ci_m1  <= cfg_ci_m1;
        r_pos_m1 <= cfg_pos_m1;
        r_co_m1  <= cfg_co_m1;
        r_ci     <= '0;
        r_pos    <= '0;
        r_co     <= '0;
        r_fbase  <= '0;
        r_wbase  <= '0;
      end else if (w_issue) begin
        r_ci <= w_ci_end ? '0 : r_ci + CI_W'(1);
        if (w_ci_end) begin
          r_pos   <= w_pos_end ? '0 : r_pos + POS_W'(1);
          r_fbase <= w_pos_end ? '0 : r_fbase + w_step;
          if (w_pos_end) begin
            r_co    <= r_co + CO_W'(1);
            r_wbase <= r_wbase + w_step;
          end
        end
      end
      r_credit <= r_credit + 2'(w_pop) - 2'(w_dec);
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_vld_sr <= '0;
    else begin
      r_vld_sr[0] <= w_issue;
      for (int i = 1; i < BUF_LAT; i++) r_vld_sr[i] <= r_vld_sr[i-1];
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_acc     <= '0;
      r_ret_cnt <= '0;
    end else if (w_start) r_ret_cnt <= '0;
    else if (w_beat) begin
      r_acc     <= w_sum;
      r_ret_cnt <= r_ret_cnt == r_ci_m1 ? '0 : r_ret_cnt + CI_W'(1);
    end
  res_fifo2 #(.W(ACC_W)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .din   (w_sum),
    .pop   (out_rdy),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty)
  );
endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: table vectors, corner sequences and random tiles against a loop-nest reference
module tb_mac_seq;
  import mac_pkg::*;
  localparam int ML = 6;
  logic        clk = 0, rstn = 0, start = 0;
  logic [7:0]  cfg_ci_m1 = 0, cfg_pos_m1 = 0, cfg_co_m1 = 0;
  logic        busy, done, fbuf_rd_en, wbuf_rd_en, mac_vld_i, out_vld;
  logic [15:0] fbuf_addr, wbuf_addr;
  logic [19:0] mac_acc = 0;
  logic        mac_vld = 0, out_rdy = 1;
  logic [27:0] out_data;
  mac_seq dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_ci_m1(cfg_ci_m1), .cfg_pos_m1(cfg_pos_m1), .cfg_co_m1(cfg_co_m1),
    .busy(busy), .done(done),
    .fbuf_rd_en(fbuf_rd_en), .fbuf_addr(fbuf_addr),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_addr(wbuf_addr),
    .mac_vld_i(mac_vld_i), .mac_acc(mac_acc), .mac_vld(mac_vld),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy)
  );
  always #5 clk = ~clk;
  typedef struct {
    int ci, pos, co;
    bit tbl;
    int v0, v1, v2, v3;
    bit rnd;
    int exp_first, exp_rd;
  } vec_t;
  int tests = 0, fails = 0;
  int exp_fa[$], exp_wa[$], exp_res[$], mac_fa[$], mac_wa[$];
  bit use_tbl = 0;
  int tbl[256];
  int seed = 0;
  int n_rd = 0, n_res = 0, done_cnt = 0, first_out = 0;
  int line_v[ML];
  bit line_k[ML];
  vec_t vecs[6];
  function automatic int mac_val(input int fa, input int wa);
    return use_tbl ? tbl[wa % 256] : ((fa * 37 + wa * 101 + seed) % 1048576) - 524288;
  endfunction
  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // behavioural MAC: consumes the address pair of each read and returns a deterministic partial sum
  always @(negedge clk) begin
    int v;
    if (!rstn) begin
      mac_fa.delete();
      mac_wa.delete();
    end
    if (fbuf_rd_en) begin
      mac_fa.push_back(int'(fbuf_addr));
      mac_wa.push_back(int'(wbuf_addr));
    end
    v = 0;
    if (mac_vld_i) begin
      if (mac_fa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mac_vld_i: strobe without a matching read");
      end else v = mac_val(mac_fa.pop_front(), mac_wa.pop_front());
    end
    mac_vld = line_k[ML-1];
    mac_acc = 20'(line_v[ML-1]);
    for (int i = ML - 1; i > 0; i--) begin
      line_k[i] = line_k[i-1];
      line_v[i] = line_v[i-1];
    end
    line_k[0] = mac_vld_i;
    line_v[0] = v;
  end
  always @(negedge clk) if (rstn) begin
    check("rd_en_pair", int'(wbuf_rd_en), int'(fbuf_rd_en));
    if (fbuf_rd_en) begin
      n_rd++;
      if (exp_fa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_read: addr %0d, expected none", fbuf_addr);
      end else begin
        check("fbuf_addr", int'(fbuf_addr), exp_fa.pop_front());
        check("wbuf_addr", int'(wbuf_addr), exp_wa.pop_front());
      end
    end
    if (out_vld && out_rdy) begin
      if (n_res == 0) first_out = $signed(out_data);
      n_res++;
      if (exp_res.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL extra_result: got %0d, expected none", $signed(out_data));
      end else check("out_data", $signed(out_data), exp_res.pop_front());
    end
    if (done) done_cnt++;
  end
  task automatic build_model(input int ci, input int pos, input int co);
    for (int o = 0; o <= co; o++)
      for (int p = 0; p <= pos; p++) begin
        int s = 0;
        for (int c = 0; c <= ci; c++) begin
          exp_fa.push_back(p * (ci + 1) + c);
          exp_wa.push_back(o * (ci + 1) + c);
          s += mac_val(p * (ci + 1) + c, o * (ci + 1) + c);
        end
        exp_res.push_back(s);
      end
    n_rd = 0;
    n_res = 0;
    done_cnt = 0;
    first_out = 0;
  endtask
  task automatic pulse_start(input int ci, input int pos, input int co);
    @(posedge clk); #1;
    cfg_ci_m1 = 8'(ci);
    cfg_pos_m1 = 8'(pos);
    cfg_co_m1 = 8'(co);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cfg_ci_m1 = 8'($urandom);
    cfg_pos_m1 = 8'($urandom);
    cfg_co_m1 = 8'($urandom);
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while (done_cnt == 0 && n < 4000) begin
      @(posedge clk); #1;
      out_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      n++;
    end
    @(posedge clk); #1;
    out_rdy = 1;
    check("done_pulses", done_cnt, 1);
    check("busy_after_done", int'(busy), 0);
    check("results_left", exp_res.size(), 0);
    check("reads_left", exp_fa.size(), 0);
  endtask
  task automatic run_tile(input int ci, input int pos, input int co, input bit rnd);
    build_model(ci, pos, co);
    pulse_start(ci, pos, co);
    wait_done(rnd);
    check("read_count", n_rd, (ci + 1) * (pos + 1) * (co + 1));
    check("result_count", n_res, (pos + 1) * (co + 1));
  endtask
  task automatic check_reset_outputs();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_fbuf_rd_en", int'(fbuf_rd_en), 0);
    check("rst_wbuf_rd_en", int'(wbuf_rd_en), 0);
    check("rst_mac_vld_i", int'(mac_vld_i), 0);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_fbuf_addr", int'(fbuf_addr), 0);
    check("rst_wbuf_addr", int'(wbuf_addr), 0);
    check("rst_out_data", int'(out_data), 0);
  endtask
  initial begin
    int stale;
    vecs[0] = '{0, 0, 0, 1, 100, 100, 100, 100, 0, 100, 1};
    vecs[1] = '{3, 0, 0, 1, -5, 10, 20, 7, 0, 32, 4};
    vecs[2] = '{3, 0, 0, 1, -300, -300, -300, -300, 0, -1200, 4};
    vecs[3] = '{2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 12};
    vecs[4] = '{255, 0, 0, 1, 524287, 524287, 524287, 524287, 0, 134217472, 256};
    vecs[5] = '{4, 3, 2, 0, 0, 0, 0, 0, 1, 0, 60};
    seed = $urandom_range(0, 100000);
    #1;
    check_reset_outputs();
    #21 rstn = 1;
    for (int i = 0; i < 6; i++) begin
      use_tbl = vecs[i].tbl;
      for (int k = 0; k < 256; k++)
        tbl[k] = k % 4 == 0 ? vecs[i].v0 : k % 4 == 1 ? vecs[i].v1 : k % 4 == 2 ? vecs[i].v2 : vecs[i].v3;
      run_tile(vecs[i].ci, vecs[i].pos, vecs[i].co, vecs[i].rnd);
      check("vec_reads", n_rd, vecs[i].exp_rd);
      if (vecs[i].tbl) check("vec_first_result", first_out, vecs[i].exp_first);
    end
    use_tbl = 0;
    build_model(0, 3, 0);
    out_rdy = 0;
    pulse_start(0, 3, 0);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 8) begin
        start = 1;
        cfg_pos_m1 = 0;
      end else start = 0;
    end
    check("bp_reads", n_rd, 2);
    check("bp_rd_en", int'(fbuf_rd_en), 0);
    check("bp_state", int'(dut.r_state), int'(WAIT));
    check("bp_out_vld", int'(out_vld), 1);
    check("bp_busy", int'(busy), 1);
    wait_done(0);
    check("bp_results", n_res, 4);
    check("bp_reads_total", n_rd, 4);
    build_model(3, 3, 1);
    pulse_start(3, 3, 1);
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", int'(busy), 1);
    #2 rstn = 0;
    #1;
    check_reset_outputs();
    exp_fa.delete();
    exp_wa.delete();
    exp_res.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rstn = 1;
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      stale += int'(out_vld) + int'(busy);
    end
    check("stale_ignored", stale, 0);
    run_tile(2, 1, 1, 0);
    for (int i = 0; i < 6; i++) begin
      seed = $urandom_range(0, 100000);
      run_tile($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
